rtype_issue_sequencer: RTL and testbench

- Multi-cycle controller that sequences the register-file/ALU datapath (REG_FILE + ALU, write-back of ALU result).
- Buffers 32-bit RV32I R-type instructions in a small FIFO and decodes them.
- Drives read/write register numbers, alu_control and regwrite for each instruction.
- Reports completion, the zero flag, illegal encodings and a retired-instruction count to the surrounding core.

---
 rtl/rtype_issue_sequencer.sv | 164 ++++++++++++++++
 tb/tb_rtype_issue_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rtype_issue_sequencer.sv
// rtype_issue_sequencer: buffers RV32I R-type instructions in a small FIFO and
// steps each through DECODE / EXEC / WRITE, driving the register-file and ALU
// controls and reporting retirement, zero flag and illegal encodings.
module rtype_issue_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr,
  output logic [4:0]       read_reg_num1,
  output logic [4:0]       read_reg_num2,
  output logic [4:0]       write_reg,
  output logic [3:0]       alu_control,
  output logic             regwrite,
  input  logic             zero_flag,
  output logic             done_valid,
  output logic             done_zero,
  output logic             illegal,
  output logic             busy,
  output logic [CNT_W-1:0] retired_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WRITE} state_t;

  state_t           state_reg, state_next;
  logic [31:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic [31:0]      ir_reg;
  logic             push, pop;
  logic             legal;
  logic [3:0]       alu_code;

  logic [4:0]       rs1_reg, rs2_reg, rd_reg;
  logic [3:0]       alu_reg;
  logic             done_valid_reg, done_zero_reg, illegal_reg;
  logic [CNT_W-1:0] retired_reg;

  // Ready is withheld while reset is asserted so nothing is accepted then.
  assign instr_ready = reset && (count_reg != FULL_CNT);
  assign push        = instr_valid && instr_ready;
  assign busy        = (state_reg != IDLE) || (count_reg != '0);

  // Instruction storage; only the pointers and count need resetting.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr_reg] <= instr;
  end

  // FIFO pointers, occupancy and the instruction register loaded on pop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ir_reg     <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        ir_reg     <= fifo_mem[rd_ptr_reg];
      end
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (!push && pop) count_reg <= count_reg - 1'b1;
    end
  end

  // Legality check and ALU operation decode of the instruction register.
  always_comb begin
    legal    = 1'b0;
    alu_code = 4'b0000;
    if (ir_reg[6:0] == 7'b0110011) begin
      if (ir_reg[31:25] == 7'b0000000) legal = 1'b1;
      else if (ir_reg[31:25] == 7'b0100000 &&
               (ir_reg[14:12] == 3'b000 || ir_reg[14:12] == 3'b101)) legal = 1'b1;
    end
    case ({ir_reg[30], ir_reg[14:12]})
      4'b0_000: alu_code = 4'b0010;
      4'b1_000: alu_code = 4'b0110;
      4'b0_001: alu_code = 4'b0011;
      4'b0_010: alu_code = 4'b0111;
      4'b0_011: alu_code = 4'b1000;
      4'b0_100: alu_code = 4'b0100;
      4'b0_101: alu_code = 4'b0101;
      4'b1_101: alu_code = 4'b1001;
      4'b0_110: alu_code = 4'b0001;
      4'b0_111: alu_code = 4'b0000;
      default:  alu_code = 4'b0000;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state and FIFO pop; WRITE chains straight into DECODE when work waits.
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (count_reg != '0) begin
          pop        = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: state_next = legal ? EXEC : IDLE;
      EXEC:   state_next = WRITE;
      WRITE: begin
        if (count_reg != '0) begin
          pop        = 1'b1;
          state_next = DECODE;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath fields, completion/illegal pulses and the retired counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rs1_reg        <= '0;
      rs2_reg        <= '0;
      rd_reg         <= '0;
      alu_reg        <= '0;
      done_valid_reg <= 1'b0;
      done_zero_reg  <= 1'b0;
      illegal_reg    <= 1'b0;
      retired_reg    <= '0;
    end else begin
      if (state_reg == DECODE && legal) begin
        rs1_reg <= ir_reg[19:15];
        rs2_reg <= ir_reg[24:20];
        rd_reg  <= ir_reg[11:7];
        alu_reg <= alu_code;
      end
      illegal_reg    <= (state_reg == DECODE) && !legal;
      done_valid_reg <= (state_reg == WRITE);
      done_zero_reg  <= (state_reg == WRITE) && zero_flag;
      if (state_reg == WRITE) retired_reg <= retired_reg + 1'b1;
    end
  end

  assign read_reg_num1 = rs1_reg;
  assign read_reg_num2 = rs2_reg;
  assign write_reg     = rd_reg;
  assign alu_control   = alu_reg;
  // Writes to x0 are suppressed; the instruction still retires.
  assign regwrite      = (state_reg == WRITE) && (rd_reg != 5'd0);
  assign done_valid    = done_valid_reg;
  assign done_zero     = done_zero_reg;
  assign illegal       = illegal_reg;
  assign retired_count = retired_reg;

endmodule

// File: tb/tb_rtype_issue_sequencer.sv
// Directed testbench for rtype_issue_sequencer.
module tb_rtype_issue_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic [4:0]  read_reg_num1, read_reg_num2, write_reg;
  logic [3:0]  alu_control;
  logic        regwrite;
  logic        zero_flag = 1'b0;
  logic        done_valid, done_zero, illegal, busy;
  logic [15:0] retired_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rw_total = 0;
  int ill_total = 0;
  int stall_seen = 0;
  int rw_q[$];
  logic [19:0] done_q[$];

  rtype_issue_sequencer #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .read_reg_num1(read_reg_num1), .read_reg_num2(read_reg_num2),
    .write_reg(write_reg), .alu_control(alu_control), .regwrite(regwrite),
    .zero_flag(zero_flag), .done_valid(done_valid), .done_zero(done_zero),
    .illegal(illegal), .busy(busy), .retired_count(retired_count)
  );

  always #5 clock = ~clock;

  // Observes the outputs mid-cycle and records write pulses and retirements.
  always @(negedge clock) begin
    cyc++;
    if (regwrite) begin
      rw_total++;
      rw_q.push_back(cyc);
    end
    if (illegal) ill_total++;
    if (done_valid)
      done_q.push_back({done_zero, alu_control, read_reg_num1, read_reg_num2, write_reg});
  end

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] r2,
                                     input logic [4:0] r1, input logic [2:0] f3,
                                     input logic [4:0] rd);
    return {f7, r2, r1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [19:0] ex(input logic z, input logic [3:0] alu,
                                     input logic [4:0] r1, input logic [4:0] r2,
                                     input logic [4:0] rd);
    return {z, alu, r1, r2, rd};
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    int n;
    n = 0;
    instr = w;
    instr_valid = 1'b1;
    while (!instr_ready && n < 100) begin
      stall_seen++;
      tick();
      n++;
    end
    check("push_timeout", 32'(n < 100), 32'd1);
    tick();
    instr_valid = 1'b0;
    $display("push %08h after %0d stall cycles", w, n);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check("idle_timeout", 32'(n < 200), 32'd1);
    tick();
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    check("rst_ready", 32'(instr_ready), 32'd0);
    check("rst_outs", {16'(retired_count), 5'(read_reg_num1 | read_reg_num2 | write_reg),
                       4'(alu_control), regwrite, done_valid, done_zero, illegal, busy}, 32'd0);
    reset = 1'b1;
    tick();
    check("rel_ready", 32'(instr_ready), 32'd1);
    check("rel_busy_cnt", {16'(retired_count), 15'd0, busy}, 32'd0);
    done_q.delete();
    rw_q.delete();
  endtask

  logic [31:0] stream_w [5];
  logic [19:0] stream_e [5];
  logic [2:0]  stall_f3 [8];
  logic [3:0]  stall_alu [8];
  logic [19:0] got;
  int rw0, ill0, ret0;

  initial begin
    // Reset and single ADD x3,x1,x2 with cycle-exact checks.
    do_reset();
    check("add_encoding", mk(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'h002081B3);
    instr = 32'h002081B3;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    check("c1_busy", 32'(busy), 32'd1);
    tick();
    tick();
    check("c3_fields", {13'd0, read_reg_num1, read_reg_num2, write_reg, alu_control},
          {13'd0, 5'd1, 5'd2, 5'd3, 4'b0010});
    check("c3_regwrite", 32'(regwrite), 32'd0);
    tick();
    check("c4_regwrite", 32'(regwrite), 32'd1);
    tick();
    check("c5_regwrite", 32'(regwrite), 32'd0);
    check("c5_done", {30'd0, done_valid, done_zero}, 32'd2);
    check("c5_count", 32'(retired_count), 32'd1);
    tick();
    check("c6_done", 32'(done_valid), 32'd0);
    check("c6_hold_rd", 32'(write_reg), 32'd3);
    check("c6_busy", 32'(busy), 32'd0);
    $display("single ADD done, retired=%0d", retired_count);

    // Back-to-back stream.
    do_reset();
    stream_w[0] = mk(7'h20, 5'd7, 5'd6, 3'd0, 5'd5);     stream_e[0] = ex(1'b0, 4'b0110, 5'd6, 5'd7, 5'd5);
    stream_w[1] = mk(7'h00, 5'd10, 5'd9, 3'd7, 5'd8);    stream_e[1] = ex(1'b0, 4'b0000, 5'd9, 5'd10, 5'd8);
    stream_w[2] = mk(7'h00, 5'd13, 5'd12, 3'd6, 5'd11);  stream_e[2] = ex(1'b0, 4'b0001, 5'd12, 5'd13, 5'd11);
    stream_w[3] = mk(7'h00, 5'd16, 5'd15, 3'd4, 5'd14);  stream_e[3] = ex(1'b0, 4'b0100, 5'd15, 5'd16, 5'd14);
    stream_w[4] = mk(7'h20, 5'd19, 5'd18, 3'd5, 5'd17);  stream_e[4] = ex(1'b0, 4'b1001, 5'd18, 5'd19, 5'd17);
    for (int i = 0; i < 5; i++) push(stream_w[i]);
    wait_idle();
    check("stream_count", 32'(retired_count), 32'd5);
    check("stream_ndone", 32'(done_q.size()), 32'd5);
    check("stream_nrw", 32'(rw_q.size()), 32'd5);
    for (int i = 0; i < 5 && done_q.size() > 0; i++) begin
      got = done_q.pop_front();
      check($sformatf("stream_entry%0d", i), 32'(got), 32'(stream_e[i]));
    end
    for (int i = 1; i < rw_q.size(); i++)
      check($sformatf("stream_gap%0d", i), 32'(rw_q[i] - rw_q[i-1]), 32'd3);

    // Queue overrun: eight pushes back to back fill the FIFO.
    do_reset();
    stall_f3[0] = 3'd1; stall_alu[0] = 4'b0011;
    stall_f3[1] = 3'd2; stall_alu[1] = 4'b0111;
    stall_f3[2] = 3'd3; stall_alu[2] = 4'b1000;
    stall_f3[3] = 3'd5; stall_alu[3] = 4'b0101;
    stall_f3[4] = 3'd0; stall_alu[4] = 4'b0010;
    stall_f3[5] = 3'd1; stall_alu[5] = 4'b0011;
    stall_f3[6] = 3'd2; stall_alu[6] = 4'b0111;
    stall_f3[7] = 3'd3; stall_alu[7] = 4'b1000;
    stall_seen = 0;
    for (int i = 0; i < 8; i++)
      push(mk(7'h00, 5'(i + 1), 5'(i), stall_f3[i], 5'(20 + i)));
    check("stall_seen", 32'(stall_seen > 0), 32'd1);
    wait_idle();
    check("stall_ndone", 32'(done_q.size()), 32'd8);
    check("stall_count", 32'(retired_count), 32'd8);
    for (int i = 0; i < 8 && done_q.size() > 0; i++) begin
      got = done_q.pop_front();
      check($sformatf("stall_entry%0d", i), 32'(got),
            32'(ex(1'b0, stall_alu[i], 5'(i), 5'(i + 1), 5'(20 + i))));
    end

    // Illegal encodings.
    rw0 = rw_total; ill0 = ill_total; ret0 = int'(retired_count);
    done_q.delete();
    push(32'h00108093);
    push(mk(7'h20, 5'd2, 5'd1, 3'd7, 5'd3));
    push(mk(7'h01, 5'd2, 5'd1, 3'd0, 5'd3));
    wait_idle();
    check("ill_pulses", 32'(ill_total - ill0), 32'd3);
    check("ill_regwrite", 32'(rw_total - rw0), 32'd0);
    check("ill_count", 32'(retired_count), 32'(ret0));
    check("ill_ndone", 32'(done_q.size()), 32'd0);

    // ADD x0 with zero flag high.
    rw0 = rw_total;
    zero_flag = 1'b1;
    push(mk(7'h00, 5'd2, 5'd1, 3'd0, 5'd0));
    wait_idle();
    zero_flag = 1'b0;
    check("x0_regwrite", 32'(rw_total - rw0), 32'd0);
    check("x0_ndone", 32'(done_q.size()), 32'd1);
    if (done_q.size() > 0) begin
      got = done_q.pop_front();
      check("x0_entry", 32'(got), 32'(ex(1'b1, 4'b0010, 5'd1, 5'd2, 5'd0)));
    end
    check("x0_count", 32'(retired_count), 32'(ret0 + 1));

    // Reset during EXEC drops the instruction.
    do_reset();
    rw0 = rw_total;
    push(32'h002081B3);
    tick();
    tick();
    check("exec_rd", 32'(write_reg), 32'd3);
    reset = 1'b0;
    #1;
    check("arst_outs", {16'(retired_count), 5'(read_reg_num1 | read_reg_num2 | write_reg),
                        4'(alu_control), regwrite, done_valid, done_zero, illegal, busy}, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("arst_norw", 32'(rw_total - rw0), 32'd0);
    check("arst_idle", {31'd0, busy}, 32'd0);
    done_q.delete();
    push(mk(7'h00, 5'd6, 5'd5, 3'd0, 5'd4));
    wait_idle();
    check("post_ndone", 32'(done_q.size()), 32'd1);
    if (done_q.size() > 0) begin
      got = done_q.pop_front();
      check("post_entry", 32'(got), 32'(ex(1'b0, 4'b0010, 5'd5, 5'd6, 5'd4)));
    end
    check("post_count", 32'(retired_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
